// File: rtl/id_counter_dco.sv
// Increment/decrement DCO for a digital PLL: turns loop-filter carry/borrow pulses into
// quarter-period phase steps on idout_o, then divides idout_o by DIV_N into the feedback clock.
module id_counter_dco #(
  parameter int DIV_N      = 16,
  parameter int DIV_WIDTH  = 8,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  carry_i,
  input  logic                  borrow_i,
  output logic                  idout_o,
  output logic                  feedback_o,
  output logic                  drop_o,
  output logic [STAT_WIDTH-1:0] addCount_o,
  output logic [STAT_WIDTH-1:0] delCount_o
);

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_N / 2 - 1);

  // Request interface: carry_i/borrow_i are single-cycle pulses with no back-pressure.
  // Each kind holds at most one pending request; opposite kinds cancel each other,
  // and a same-kind repeat while one is still pending is discarded and flagged on drop_o.

  logic [1:0]            phase_q, phase_d;
  logic                  carry_pend_q, carry_pend_d;
  logic                  borrow_pend_q, borrow_pend_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic                  feedback_q, feedback_d;
  logic                  drop_q, drop_d;
  logic [STAT_WIDTH-1:0] add_cnt_q, del_cnt_q;
  logic                  consume_c, consume_b, rise;

  always_comb begin
    consume_c     = (phase_q == 2'd0) && carry_pend_q;
    consume_b     = (phase_q == 2'd0) && !carry_pend_q && borrow_pend_q;
    phase_d       = phase_q + 2'd1;
    carry_pend_d  = carry_pend_q && !consume_c;
    borrow_pend_d = borrow_pend_q && !consume_b;
    drop_d        = 1'b0;
    div_cnt_d     = div_cnt_q;
    feedback_d    = feedback_q;

    if (consume_c) begin
      phase_d = 2'd2;
    end else if (consume_b) begin
      phase_d = 2'd0;
    end

    // The *_pend_d values already reflect consumption, so a request landing on the
    // consuming edge sees an empty slot and is latched rather than dropped.
    if (carry_i && !borrow_i) begin
      if (borrow_pend_d) begin
        borrow_pend_d = 1'b0;
      end else if (carry_pend_d) begin
        drop_d = 1'b1;
      end else begin
        carry_pend_d = 1'b1;
      end
    end else if (borrow_i && !carry_i) begin
      if (carry_pend_d) begin
        carry_pend_d = 1'b0;
      end else if (borrow_pend_d) begin
        drop_d = 1'b1;
      end else begin
        borrow_pend_d = 1'b1;
      end
    end

    rise = !phase_q[1] && phase_d[1];
    if (rise) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d  = '0;
        feedback_d = !feedback_q;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q       <= 2'd0;
      carry_pend_q  <= 1'b0;
      borrow_pend_q <= 1'b0;
      div_cnt_q     <= '0;
      feedback_q    <= 1'b0;
      drop_q        <= 1'b0;
      add_cnt_q     <= '0;
      del_cnt_q     <= '0;
    end else begin
      phase_q       <= phase_d;
      carry_pend_q  <= carry_pend_d;
      borrow_pend_q <= borrow_pend_d;
      div_cnt_q     <= div_cnt_d;
      feedback_q    <= feedback_d;
      drop_q        <= drop_d;
      add_cnt_q     <= add_cnt_q + {{(STAT_WIDTH-1){1'b0}}, consume_c};
      del_cnt_q     <= del_cnt_q + {{(STAT_WIDTH-1){1'b0}}, consume_b};
    end
  end

  assign idout_o    = phase_q[1];
  assign feedback_o = feedback_q;
  assign drop_o     = drop_q;
  assign addCount_o = add_cnt_q;
  assign delCount_o = del_cnt_q;

endmodule

// File: tb/tb_id_counter_dco.sv
// Bench for id_counter_dco: free-run timing, table of carry/borrow pulse patterns with
// expected idout periods, and an asynchronous reset while a borrow is pending.
module tb_id_counter_dco;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        carry_i;
  logic        borrow_i;
  logic        idout_o;
  logic        feedback_o;
  logic        drop_o;
  logic [15:0] addCount_o;
  logic [15:0] delCount_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base_cyc;
  int exp_add;
  int exp_del;
  logic [7:0] exp_q[$];

  typedef struct {
    string      name;
    logic [7:0] carry_pat;
    logic [7:0] borrow_pat;
    int         per[4];
    int         add_inc;
    int         del_inc;
    int         drops;
  } vec_t;

  vec_t vecs[9];

  id_counter_dco #(.DIV_N(16), .DIV_WIDTH(8), .STAT_WIDTH(16)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .carry_i    (carry_i),
    .borrow_i   (borrow_i),
    .idout_o    (idout_o),
    .feedback_o (feedback_o),
    .drop_o     (drop_o),
    .addCount_o (addCount_o),
    .delCount_o (delCount_o)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [7:0] c, input logic [7:0] b,
                              input int p0, input int p1, input int p2, input int p3,
                              input int a, input int d, input int dr);
    vec_t v;
    v.name = name;
    v.carry_pat = c;
    v.borrow_pat = b;
    v.per[0] = p0;
    v.per[1] = p1;
    v.per[2] = p2;
    v.per[3] = p3;
    v.add_inc = a;
    v.del_inc = d;
    v.drops = dr;
    return v;
  endfunction

  // driver tasks
  task automatic apply_reset();
    reset_i  = 1'b1;
    carry_i  = 1'b0;
    borrow_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {idout_o, feedback_o, drop_o, addCount_o, delCount_o}, 64'd0);
    @(negedge clk);
    reset_i  = 1'b0;
    base_cyc = cyc;
    exp_add  = 0;
    exp_del  = 0;
  endtask

  task automatic wait_rise(output bit found);
    logic prev;
    found = 1'b0;
    prev  = idout_o;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (idout_o && !prev) found = 1'b1;
      prev = idout_o;
    end
  endtask

  // Bit k of a pattern is driven during the k-th cycle after the syncing idout rise.
  task automatic run_vec(input vec_t v);
    bit   found;
    logic prev;
    int   last, got, drops, k, period;
    wait_rise(found);
    check({v.name, "_sync"}, found, 1'b1);
    last = cyc;
    prev = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(v.per[i]));
    exp_add += v.add_inc;
    exp_del += v.del_inc;
    got = 0;
    drops = 0;
    k = 0;
    while (got < 4 && k < 40) begin
      carry_i  = (k < 8) ? v.carry_pat[k[2:0]] : 1'b0;
      borrow_i = (k < 8) ? v.borrow_pat[k[2:0]] : 1'b0;
      @(negedge clk);
      k++;
      if (drop_o) drops++;
      if (idout_o && !prev) begin
        period = cyc - last;
        last = cyc;
        check({v.name, "_period"}, 64'(period), 64'(exp_q.pop_front()));
        got++;
      end
      prev = idout_o;
    end
    carry_i  = 1'b0;
    borrow_i = 1'b0;
    check({v.name, "_rise_count"}, 64'(got), 64'd4);
    exp_q.delete();
    check({v.name, "_drops"}, 64'(drops), 64'(v.drops));
    check({v.name, "_add_count"}, 64'(addCount_o), 64'(exp_add));
    check({v.name, "_del_count"}, 64'(delCount_o), 64'(exp_del));
  endtask

  // Phase after edge n of a clean run is n mod 4, so idout is high when n mod 4 >= 2.
  task automatic check_nominal(input string name, input int ncyc);
    int   n;
    logic exp_id;
    logic exp_fb;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      n = cyc - base_cyc;
      exp_id = (n % 4) >= 2;
      exp_fb = (n >= 30) ? (((n - 30) / 32) % 2 == 0) : 1'b0;
      check({name, "_idout_fb_drop"}, {idout_o, feedback_o, drop_o}, {exp_id, exp_fb, 1'b0});
    end
  endtask

  initial begin
    bit found;
    vecs[0] = mk("idle",              8'h00, 8'h00, 4, 4, 4, 4, 0, 0, 0);
    vecs[1] = mk("carry_at_phase1",   8'h08, 8'h00, 4, 3, 4, 4, 1, 0, 0);
    vecs[2] = mk("borrow_at_phase1",  8'h00, 8'h08, 4, 5, 4, 4, 0, 1, 0);
    vecs[3] = mk("carry_borrow_same", 8'h08, 8'h08, 4, 4, 4, 4, 0, 0, 0);
    vecs[4] = mk("carry_then_borrow", 8'h01, 8'h02, 4, 4, 4, 4, 0, 0, 0);
    vecs[5] = mk("borrow_then_carry", 8'h02, 8'h01, 4, 4, 4, 4, 0, 0, 0);
    vecs[6] = mk("double_carry",      8'h03, 8'h00, 3, 4, 4, 4, 1, 0, 1);
    vecs[7] = mk("carry_on_consume",  8'h06, 8'h00, 3, 3, 4, 4, 2, 0, 0);
    vecs[8] = mk("double_borrow",     8'h00, 8'h03, 5, 4, 4, 4, 0, 1, 1);

    apply_reset();
    check_nominal("free_run", 200);
    check("free_run_add", 64'(addCount_o), 64'd0);
    check("free_run_del", 64'(delCount_o), 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // async reset mid-period with a borrow pending
    wait_rise(found);
    check("midreset_sync", found, 1'b1);
    borrow_i = 1'b1;
    @(negedge clk);
    borrow_i = 1'b0;
    check("midreset_pre_idout", idout_o, 1'b1);
    #2 reset_i = 1'b1;
    #1;
    check("midreset_outputs", {idout_o, feedback_o, drop_o, addCount_o, delCount_o}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset_i  = 1'b0;
    base_cyc = cyc;
    check_nominal("after_midreset", 24);
    check("after_midreset_del", 64'(delCount_o), 64'd0);
    check("after_midreset_add", 64'(addCount_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_counter_dco.md
Name: id_counter_dco

Overview:
- Increment/decrement digitally-controlled oscillator (ID counter); the stage directly downstream of the K-counter loop filter in the digital PLL.
- Consumes the loop filter's one-cycle carry (count hit +max) and borrow (count hit -max) pulses.
- Adds or deletes a quarter-period of phase on the oscillator output, then divides that output by N to produce the feedback clock for the phase detector.

Parameters:
- DIV_N, 16, feedback divide ratio applied to idout_o; must be even and >= 2.
- DIV_WIDTH, 8, width of the internal divider counter; must satisfy 2^DIV_WIDTH >= DIV_N/2.
- STAT_WIDTH, 16, width of the add/delete statistics counters.

Ports:
- clk_i  in  1  system clock (4x nominal idout frequency).
- reset_i  in  1  asynchronous, active-high reset.
- carry_i  in  1  one-cycle pulse from loop filter max trigger; request to advance phase.
- borrow_i  in  1  one-cycle pulse from loop filter min trigger; request to retard phase.
- idout_o  out  1  oscillator output, nominal period 4 clk, registered.
- feedback_o  out  1  idout_o divided by DIV_N, 50% duty, registered.
- drop_o  out  1  one-cycle pulse: a request was discarded because one of the same kind was already pending.
- addCount_o  out  STAT_WIDTH  number of carries applied, wraps.
- delCount_o  out  STAT_WIDTH  number of borrows applied, wraps.

Behaviour:
- Reset (async, active-high):
  - All outputs are 0.
  - Internal state cleared: 2-bit phase = 0, carryPend = 0, borrowPend = 0, divider count = 0.
  - Reset mid-operation discards pending requests immediately.
- Oscillator:
  - idout_o = phase[1] (registered).
  - With p = current phase, evaluated each clk edge in priority order:
    - p==0 && carryPend: phase <= 2, clear carryPend, addCount_o += 1.
    - else p==0 && borrowPend: phase stays 0, clear borrowPend, delCount_o += 1.
    - otherwise: phase <= p+1 (mod 4).
  - Resulting periods: nominal 4 clk; an applied carry gives one period of 3 clk (low phase 1 clk); an applied borrow gives one period of 5 clk (low phase 3 clk).
  - Requests are applied only at period start (p==0); worst-case latency from a pulse to its effect is 4 clk.
- Pending request logic, on each edge, in priority order:
  - carry_i && borrow_i in the same cycle: net zero, both ignored, no drop_o.
  - carry_i while borrowPend (and no consumption this edge): clear borrowPend; carry not latched; counters unchanged.
  - borrow_i while carryPend (and no consumption this edge): clear carryPend; borrow not latched; counters unchanged.
  - carry_i while carryPend already set and not consumed this edge: discard, drop_o = 1 for one cycle. Same rule for borrow_i.
  - A request arriving on the same edge its pending flag is consumed is latched as a new pending request; no drop.
  - Otherwise carry_i sets carryPend and borrow_i sets borrowPend.
- Divider:
  - Advances on each idout rising event (phase[1] goes 0 -> 1 at this edge).
  - When the count equals DIV_N/2-1: the count resets to 0 and feedback_o toggles. Otherwise the count increments.
  - feedback_o period is DIV_N idout periods: nominally 4*DIV_N clk.
- Statistics counters wrap modulo 2^STAT_WIDTH with no saturation.

Test Plan:
- Reset, then free-run 200 clk with no requests -> idout_o period exactly 4 (2 low / 2 high); feedback_o period 64 clk with DIV_N=16; counters 0.
- Single carry_i pulse when phase==1 -> next idout period is 3 clk (1 low); all following periods are 4; addCount_o=1; feedback_o edge arrives 1 clk early.
- Single borrow_i pulse -> exactly one idout period of 5 clk (3 low); delCount_o=1; feedback_o edge arrives 1 clk late.
- carry_i and borrow_i asserted together, then carry_i followed by borrow_i 1 clk later (before period start) -> idout stays at nominal period 4; both counters 0; drop_o never asserted.
- Two carry_i pulses 1 clk apart within one period -> drop_o pulses once on the second; exactly one 3-clk period; addCount_o=1.
- Assert reset_i asynchronously mid-period with borrowPend set -> all outputs 0 immediately; after release: nominal period 4, no 5-clk period, delCount_o=0.
